// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH independent clock dividers with shadowed, glitch-free divisor updates.
// Optional macro CLKDIV_SYNC_EN adds sync_i, which phase-aligns every channel.
module clkdiv_multi #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 26,
    parameter int DEF_DIV = 50000000,
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_we_i,
    input  logic [CHW-1:0]    cfg_ch_i,
    input  logic [WIDTH-1:0]  cfg_div_i,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_i,
`endif
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_o
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]  shadow_q [NUM_CH];
    logic [WIDTH-1:0]  shadow_d [NUM_CH];
    logic [WIDTH-1:0]  active_q [NUM_CH];
    logic [WIDTH-1:0]  active_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q    [NUM_CH];
    logic [WIDTH-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic              sync;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // shadow_d is the forwarded value, so a write coinciding with a wrap takes effect at that wrap.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            shadow_d[c] = shadow_q[c];
            if (cfg_we_i && (cfg_ch_i == CHW'(c)))
                shadow_d[c] = cfg_div_i;
            active_d[c] = active_q[c];
            cnt_d[c]    = cnt_q[c];
            tick_d[c]   = 1'b0;
            clk_d[c]    = clk_q[c];
            if (sync || !en_i[c] || (active_q[c] == '0)) begin
                cnt_d[c]    = '0;
                clk_d[c]    = 1'b1;
                active_d[c] = shadow_d[c];
            end else if (cnt_q[c] == (active_q[c] - ONE)) begin
                cnt_d[c]    = '0;
                tick_d[c]   = 1'b1;
                clk_d[c]    = ~clk_q[c];
                active_d[c] = shadow_d[c];
            end else begin
                cnt_d[c] = cnt_q[c] + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= DEF;
                active_q[c] <= DEF;
                cnt_q[c]    <= '0;
            end
            tick_q <= '0;
            clk_q  <= '1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick_o = tick_q;
    assign clk_o  = clk_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: a 4-channel and a 3-channel instance share stimulus and are
// checked each cycle against a countdown/parity model, plus directed literal sequences.
module tb_clkdiv_multi;

    localparam int W   = 8;
    localparam int DEF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en  = '0;
    logic       we  = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic       sync = 1'b0;
    logic [3:0] tick_a, clk_a;
    logic [2:0] tick_b, clk_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    always #5 clk = ~clk;

    clkdiv_multi #(.NUM_CH(4), .WIDTH(W), .DEF_DIV(DEF)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_we_i(we), .cfg_ch_i(cfg_ch),
        .cfg_div_i(cfg_div),
`ifdef CLKDIV_SYNC_EN
        .sync_i(sync),
`endif
        .tick_o(tick_a), .clk_o(clk_a));

    clkdiv_multi #(.NUM_CH(3), .WIDTH(W), .DEF_DIV(DEF)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en[2:0]), .cfg_we_i(we), .cfg_ch_i(cfg_ch),
        .cfg_div_i(cfg_div),
`ifdef CLKDIV_SYNC_EN
        .sync_i(sync),
`endif
        .tick_o(tick_b), .clk_o(clk_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: per channel, cycles remaining until the next tick and tick-count parity.
    int m_sh  [2][4];
    int m_ac  [2][4];
    int m_rem [2][4];
    bit m_run [2][4];
    bit m_par [2][4];
    bit m_tk  [2][4];
    int nd, nch;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            nch = (m == 0) ? 4 : 3;
            for (int c = 0; c < 4; c++) begin
                if (rst) begin
                    m_sh[m][c] = DEF; m_ac[m][c] = DEF;
                    m_run[m][c] = 0; m_par[m][c] = 0; m_tk[m][c] = 0;
                end else begin
                    nd = (we && int'(cfg_ch) == c && c < nch) ? int'(cfg_div) : m_sh[m][c];
                    m_sh[m][c] = nd;
                    m_tk[m][c] = 0;
                    if (sync || !en[c] || m_ac[m][c] == 0) begin
                        m_run[m][c] = 0; m_par[m][c] = 0; m_ac[m][c] = nd;
                    end else begin
                        if (!m_run[m][c]) begin
                            m_run[m][c] = 1; m_rem[m][c] = m_ac[m][c];
                        end
                        m_rem[m][c]--;
                        if (m_rem[m][c] == 0) begin
                            m_tk[m][c] = 1; m_par[m][c] = ~m_par[m][c];
                            m_ac[m][c] = nd; m_rem[m][c] = nd;
                        end
                    end
                end
            end
        end
    end

    logic [3:0] e_ta, e_ca;
    logic [2:0] e_tb, e_cb;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < 4; c++) begin
                e_ta[c] = m_tk[0][c]; e_ca[c] = ~m_par[0][c];
            end
            for (int c = 0; c < 3; c++) begin
                e_tb[c] = m_tk[1][c]; e_cb[c] = ~m_par[1][c];
            end
            check("model tick_a", 32'(tick_a), 32'(e_ta));
            check("model clk_a",  32'(clk_a),  32'(e_ca));
            check("model tick_b", 32'(tick_b), 32'(e_tb));
            check("model clk_b",  32'(clk_b),  32'(e_cb));
        end
    end

    task automatic wr(input int ch, input int div);
        we = 1'b1; cfg_ch = 2'(ch); cfg_div = W'(div);
        @(negedge clk);
        we = 1'b0;
    endtask

    logic [15:0] cap_t, cap_c, cap_u;
    int cnt0, cnt1, cnt2, kfound;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1;
        check("reset tick_a", 32'(tick_a), 32'h0);
        check("reset clk_a",  32'(clk_a),  32'hF);
        check("reset tick_b", 32'(tick_b), 32'h0);
        check("reset clk_b",  32'(clk_b),  32'h7);

        // ch0 div=3 written while disabled
        wr(0, 3);
        en = 4'b0001;
        cap_t = '0; cap_c = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            cap_t[k-1] = tick_a[0]; cap_c[k-1] = clk_a[0];
        end
        check("div3 tick pattern", 32'(cap_t[11:0]), 32'b1001_0010_0100);
        check("div3 clk pattern",  32'(cap_c[11:0]), 32'b1000_1110_0011);

        // ch1 div=4, rewrite to 2 mid-period
        wr(1, 4);
        en = 4'b0011;
        cap_t = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            cap_t[k-1] = tick_a[1];
            if (k == 2) begin we = 1'b1; cfg_ch = 2'd1; cfg_div = W'(2); end
            if (k == 3) we = 1'b0;
        end
        check("mid-period rewrite", 32'(cap_t[8:0]), 32'b0_1010_1000);

        // ch2 div=3, write 5 exactly on the wrap edge
        wr(2, 3);
        en = 4'b0111;
        cap_t = '0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            cap_t[k-1] = tick_a[2];
            if (k == 2) begin we = 1'b1; cfg_ch = 2'd2; cfg_div = W'(5); end
            if (k == 3) we = 1'b0;
        end
        check("write on wrap", 32'(cap_t[12:0]), 32'b1_0000_1000_0100);

        // ch3 div=1 then div=0
        wr(3, 1);
        en = 4'b1111;
        cap_t = '0; cap_c = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cap_t[k-1] = tick_a[3]; cap_c[k-1] = clk_a[3];
        end
        check("div1 tick", 32'(cap_t[3:0]), 32'b1111);
        check("div1 clk",  32'(cap_c[3:0]), 32'b1010);
        wr(3, 0);
        @(negedge clk);
        check("div0 tick", 32'(tick_a[3]), 32'd0);
        check("div0 clk",  32'(clk_a[3]),  32'd1);
        repeat (4) @(negedge clk);
        check("div0 tick held", 32'(tick_a[3]), 32'd0);
        check("div0 clk held",  32'(clk_a[3]),  32'd1);

        // out-of-range channel on the 3-channel instance
        wr(3, 1);
        cnt0 = 0; cnt1 = 0; cnt2 = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            cnt0 += int'(tick_b[0]); cnt1 += int'(tick_b[1]); cnt2 += int'(tick_b[2]);
        end
        check("bad ch: b0 ticks/30", 32'(cnt0), 32'd10);
        check("bad ch: b1 ticks/30", 32'(cnt1), 32'd15);
        check("bad ch: b2 ticks/30", 32'(cnt2), 32'd6);

        // reset mid-count
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst tick_a", 32'(tick_a), 32'h0);
        check("mid rst clk_a",  32'(clk_a),  32'hF);
        check("mid rst tick_b", 32'(tick_b), 32'h0);
        check("mid rst clk_b",  32'(clk_b),  32'h7);
        rst = 1'b0;
        kfound = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (tick_a[0] && kfound == 0) kfound = k;
        end
        check("first tick after reset (DEF_DIV)", 32'(kfound), 32'(DEF));

`ifdef CLKDIV_SYNC_EN
        en = 4'b0000;
        @(negedge clk);
        wr(0, 3);
        wr(1, 6);
        en = 4'b0001;
        repeat (2) @(negedge clk);
        en = 4'b0011;
        repeat (5) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        cap_t = '0; cap_u = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            cap_t[k-1] = tick_a[0]; cap_u[k-1] = tick_a[1];
        end
        check("sync ch0", 32'(cap_t[5:0]), 32'b100100);
        check("sync ch1", 32'(cap_u[5:0]), 32'b100000);
`endif

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            en = 4'($urandom);
            we = ($urandom_range(0, 3) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = W'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
`ifdef CLKDIV_SYNC_EN
            sync = ($urandom_range(0, 49) == 0);
`endif
            @(negedge clk);
        end
        we = 1'b0; rst = 1'b0; sync = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
